// File: rtl/mips_fetch_pkg.sv
// Shared types for the instruction-fetch slice: FIFO entry payload and fetch FSM states.
package mips_fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between fetch and decode.
// Flush wins over push; a pop alongside a flush is ignored.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Pointers are power-of-two sized and wrap on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives imem, buffers words for decode,
// and handles redirects (flush + PC load) and halt requests.
module ifetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_instr,
    output logic [31:0]            if_pc,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    output logic                   misalign_err,
    input  logic                   halt_req,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_d;
    logic              push_c;
    logic              pop_c;
    logic              room_c;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;
    logic              unused_ok;

    assign unused_ok = ^redirect_target[31:ADDR_W];

    assign imem_addr = 32'({fetch_pc[ADDR_W-1:2], 2'b00});
    assign if_valid  = (fifo_count != '0);
    assign pop_c     = if_valid && if_ready;
    assign room_c    = (fifo_count < CNT_W'(DEPTH)) || pop_c;
    assign wr_entry  = '{pc: imem_addr, instr: imem_rdata};
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign halted    = (state_q == ST_HALT) && !if_valid;

    // Next state, push decision and next PC; redirect overrides any push.
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        pc_d    = fetch_pc;
        case (state_q)
            ST_RUN:  if (halt_req)  state_d = ST_HALT;
            ST_HALT: if (!halt_req) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        push_c = (state_d == ST_RUN) && !halt_req && !redirect_valid && room_c;
        if (redirect_valid) begin
            pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
        end else if (push_c) begin
            pc_d = fetch_pc + ADDR_W'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            fetch_pc     <= RESET_PC[ADDR_W-1:0];
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc     <= pc_d;
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the fetch stream.
module tb_ifetch_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [31:0]            imem_addr;
    logic [31:0]            imem_rdata;
    logic                   if_valid;
    logic                   if_ready;
    logic [31:0]            if_instr;
    logic [31:0]            if_pc;
    logic                   redirect_valid;
    logic [31:0]            redirect_target;
    logic                   misalign_err;
    logic                   halt_req;
    logic                   halted;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered PCs, fetch PC, halt level, misalign pulse.
    int q[$];
    int m_pc;
    bit m_halt;
    bit m_mis;

    ifetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .misalign_err   (misalign_err),
        .halt_req       (halt_req),
        .halted         (halted),
        .fifo_count     (fifo_count)
    );

    // instructionMemory: word i holds 32'h1000_0000 + i.
    assign imem_rdata = 32'h1000_0000 + 32'(imem_addr[ADDR_W-1:2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input int pc);
        return 32'h1000_0000 + 32'(pc / 4);
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = 0;
        m_halt = 1'b0;
        m_mis  = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a negedge), advance model at the edge, return at next negedge.
    task automatic cyc(input bit rdy, input bit redir, input logic [31:0] tgt, input bit hlt);
        bit pop;
        bit push;
        int sz;
        if_ready        = rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        halt_req        = hlt;
        @(posedge clk);
        sz     = q.size();
        pop    = (sz != 0) && rdy;
        m_mis  = redir && (tgt[1:0] != 2'b00);
        m_halt = hlt;
        if (redir) begin
            q.delete();
            m_pc = int'(tgt[ADDR_W-1:0]) & ~3;
        end else begin
            push = !hlt && ((sz < int'(DEPTH)) || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(m_pc);
                m_pc = (m_pc + 4) % 4096;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt_req        = 1'b0;
        model_reset();
        #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0b exp 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got %h exp 0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", if_pc); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b exp 0", misalign_err); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, if_valid); end
            checks++; if (if_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_pc, 32'(4 * i)); end
            checks++; if (if_instr !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, if_instr, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d] got %h exp 0", i, if_pc); end
        end
        checks++; if (fifo_count !== 2'(DEPTH)) begin errors++; $display("FAIL stall_count got %0d exp %0d", fifo_count, DEPTH); end
        checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL stall_imem_addr got %h exp 8", imem_addr); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * j)) begin errors++; $display("FAIL stall_drain[%0d] got v=%0b pc=%h exp pc=%h", j, if_valid, if_pc, 32'(4 * j)); end
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_redirect();
        cyc(1'b1, 1'b1, 32'd32, 1'b0);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %0b exp 0", if_valid); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL redir_flush_count got %0d exp 0", fifo_count); end
        checks++; if (imem_addr !== 32'd32) begin errors++; $display("FAIL redir_imem_addr got %h exp 20", imem_addr); end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(32 + 4 * k)) begin errors++; $display("FAIL redir_pc[%0d] got v=%0b pc=%h exp %h", k, if_valid, if_pc, 32'(32 + 4 * k)); end
            checks++; if (if_instr !== 32'h1000_0008 + 32'(k)) begin errors++; $display("FAIL redir_instr[%0d] got %h exp %h", k, if_instr, 32'h1000_0008 + 32'(k)); end
        end
    endtask

    task automatic test_misalign();
        cyc(1'b1, 1'b1, 32'd35, 1'b0);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse got %0b exp 1", misalign_err); end
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %0b exp 0", misalign_err); end
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd32) begin errors++; $display("FAIL misalign_pc got v=%0b pc=%h exp 20", if_valid, if_pc); end
        cyc(1'b1, 1'b1, 32'd4092, 1'b0);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL aligned_no_pulse got %0b exp 0", misalign_err); end
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (if_pc !== 32'd4092 || if_instr !== 32'h1000_03FF) begin errors++; $display("FAIL wrap_first got pc=%h instr=%h exp ffc/100003ff", if_pc, if_instr); end
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (if_pc !== 32'd0 || if_instr !== 32'h1000_0000) begin errors++; $display("FAIL wrap_second got pc=%h instr=%h exp 0/10000000", if_pc, if_instr); end
    endtask

    task automatic test_halt();
        bit got;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL halt_prefill got %0d exp 2", fifo_count); end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if (halted !== 1'b0 || fifo_count !== 2'd1) begin errors++; $display("FAIL halt_drain1 got halted=%0b cnt=%0d exp 0/1", halted, fifo_count); end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++; if (halted !== 1'b1 || fifo_count !== 2'd0) begin errors++; $display("FAIL halt_drain2 got halted=%0b cnt=%0d exp 1/0", halted, fifo_count); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            checks++; if (halted !== 1'b1 || fifo_count !== 2'd0 || imem_addr !== 32'd8) begin errors++; $display("FAIL halt_hold[%0d] got halted=%0b cnt=%0d addr=%h exp 1/0/8", i, halted, fifo_count, imem_addr); end
        end
        cyc(1'b1, 1'b1, 32'd52, 1'b1);
        checks++; if (halted !== 1'b1 || imem_addr !== 32'd52 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_redirect got halted=%0b addr=%h v=%0b exp 1/34/0", halted, imem_addr, if_valid); end
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            got = if_valid;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL resume_timeout got if_valid=0 exp 1 within 4 cycles");
        end else if (if_pc !== 32'd52 || halted !== 1'b0) begin
            errors++; $display("FAIL resume_pc got pc=%h halted=%0b exp 34/0", if_pc, halted);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (if_valid !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL async_rst got v=%0b cnt=%0d exp 0/0", if_valid, fifo_count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_rst_addr got %h exp 0", imem_addr); end
        if_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin errors++; $display("FAIL async_restart got v=%0b pc=%h instr=%h exp 1/0/10000000", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_random();
        int halt_left;
        bit rdy;
        bit redir;
        bit hlt;
        logic [31:0] tgt;
        halt_left = 0;
        for (int c = 0; c < 400; c++) begin
            rdy   = ($urandom % 4) != 0;
            redir = ($urandom % 12) == 0;
            tgt   = $urandom;
            if (halt_left == 0 && ($urandom % 20) == 0) halt_left = 1 + int'($urandom % 6);
            hlt = (halt_left != 0);
            if (halt_left != 0) halt_left--;
            cyc(rdy, redir, tgt, hlt);
            checks++; if (fifo_count !== 2'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", c, fifo_count, q.size()); end
            checks++; if (if_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d] got %0b exp %0b", c, if_valid, q.size() != 0); end
            checks++; if (imem_addr !== 32'(m_pc)) begin errors++; $display("FAIL rand_addr[%0d] got %h exp %h", c, imem_addr, 32'(m_pc)); end
            checks++; if (halted !== (m_halt && q.size() == 0)) begin errors++; $display("FAIL rand_halted[%0d] got %0b exp %0b", c, halted, m_halt && q.size() == 0); end
            checks++; if (misalign_err !== m_mis) begin errors++; $display("FAIL rand_misalign[%0d] got %0b exp %0b", c, misalign_err, m_mis); end
            if (q.size() != 0) begin
                checks++; if (if_pc !== 32'(q[0]) || if_instr !== word_at(q[0])) begin errors++; $display("FAIL rand_head[%0d] got pc=%h instr=%h exp pc=%h instr=%h", c, if_pc, if_instr, 32'(q[0]), word_at(q[0])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
